// File: rtl/jt10_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt10_acc_pkg
// Purpose  : Shared helpers for the stereo frame accumulator: a
//            width-parametrised saturating clamp, its overflow detect, and
//            the algorithm-to-sum-enable decode.
// Revision : 1.0 - initial release
// ============================================================================
package jt10_acc_pkg;

    // Working width for the saturation helpers; wide enough for any legal
    // WACC/WOUT plus the carry of one addition.
    localparam int SAT_W = 64;

    // Algorithms that differ from the default "only the last operator" mix.
    localparam logic [2:0] ALG_4 = 3'd4;
    localparam logic [2:0] ALG_5 = 3'd5;
    localparam logic [2:0] ALG_6 = 3'd6;
    localparam logic [2:0] ALG_7 = 3'd7;

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat_to(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    // True when clamping x to w bits would change it.
    function automatic logic sat_hit(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        return sat_to(x, w) != x;
    endfunction

    // Which operator stage outputs belong in the channel mix for each
    // algorithm. Stage 3 never appears on its own in any mix.
    function automatic logic alg_sum_en(
        input logic [2:0] alg,
        input logic       s1,
        input logic       s2,
        input logic       s4
    );
        case (alg)
            ALG_4:        return s2 | s4;
            ALG_5, ALG_6: return ~s1;
            ALG_7:        return 1'b1;
            default:      return s4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt10_sat_acc.sv
`default_nettype none
// ============================================================================
// Module   : jt10_sat_acc
// Purpose  : One side of the stereo mixer: saturating WACC-bit frame
//            accumulator, frame-boundary latch to a WOUT-bit sample with
//            mute, and a per-frame sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module jt10_sat_acc
    import jt10_acc_pkg::*;
#(
    parameter int WACC = 19,
    parameter int WOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   zero,
    input  logic signed [WACC-1:0] term,
    input  logic                   term_en,
    input  logic                   mute,
    output logic signed [WOUT-1:0] dout,
    output logic                   ovf
);

    logic signed [WACC-1:0]  acc;
    logic                    frame_ovf;

    logic signed [WACC-1:0]  term_v;
    logic signed [SAT_W-1:0] acc_w;
    logic signed [SAT_W-1:0] sum_w;
    logic signed [WACC-1:0]  acc_next;
    logic                    acc_sat;
    logic signed [WOUT-1:0]  out_next;
    logic                    out_sat;

    // Next accumulator value and the clamped output candidate, with the
    // overflow detects for both clamps.
    always_comb begin
        term_v   = term_en ? term : '0;
        acc_w    = SAT_W'(acc);
        sum_w    = acc_w + SAT_W'(term_v);
        acc_next = WACC'(sat_to(sum_w, WACC));
        acc_sat  = sat_hit(sum_w, WACC);
        out_next = WOUT'(sat_to(acc_w, WOUT));
        out_sat  = sat_hit(acc_w, WOUT);
    end

    // Accumulate between boundaries; on a boundary publish the finished
    // frame and restart the sum with the boundary slot's own term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_ovf <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (clk_en) begin
            if (zero) begin
                dout      <= mute ? '0 : out_next;
                ovf       <= frame_ovf | out_sat;
                acc       <= term_v;
                frame_ovf <= 1'b0;
            end else begin
                acc       <= acc_next;
                frame_ovf <= frame_ovf | acc_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt10_multi_acc.sv
`default_nettype none
// ============================================================================
// Module   : jt10_multi_acc
// Purpose  : Stereo frame accumulator for the FM/ADPCM mixer. Sums the FM
//            operator outputs selected by algorithm and pan, replaces the
//            FM term with an external stereo source on that source's
//            channel slot, and emits a saturated stereo sample per frame
//            with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module jt10_multi_acc
    import jt10_acc_pkg::*;
#(
    parameter int              WIN      = 14,
    parameter int              WEXT     = 16,
    parameter int              WACC     = 19,
    parameter int              WOUT     = 16,
    parameter int              NEXT     = 2,
    parameter logic [3*NEXT-1:0] EXT_SLOT = {3'd6, 3'd2},
    parameter int              EXT_SHL  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic signed [WIN-1:0]  op_result,
    input  logic [1:0]             rl,
    input  logic [2:0]             alg,
    input  logic                   s1_enters,
    input  logic                   s2_enters,
    input  logic                   s3_enters,
    input  logic                   s4_enters,
    input  logic [2:0]             cur_ch,
    input  logic                   zero,
    input  logic [NEXT*WEXT-1:0]   ext_l,
    input  logic [NEXT*WEXT-1:0]   ext_r,
    input  logic [NEXT-1:0]        ext_en,
    input  logic [1:0]             mute,
    output logic signed [WOUT-1:0] left,
    output logic signed [WOUT-1:0] right,
    output logic                   sample,
    output logic [1:0]             ovf
);

    logic                   sum_en;
    logic                   ext_hit;
    logic signed [WACC-1:0] ext_term_l;
    logic signed [WACC-1:0] ext_term_r;
    logic signed [WACC-1:0] fm_term;
    logic signed [WACC-1:0] term_l;
    logic signed [WACC-1:0] term_r;
    logic                   en_l;
    logic                   en_r;

    // Stage 3 never selects a term on its own; kept only for port symmetry.
    logic unused_s3;
    assign unused_s3 = s3_enters;

    // Pick this slot's term: an enabled external source owning the slot
    // wins (lowest index first, hence the descending scan), otherwise the
    // FM operator output gated by algorithm and pan.
    always_comb begin
        sum_en     = alg_sum_en(alg, s1_enters, s2_enters, s4_enters);
        ext_hit    = 1'b0;
        ext_term_l = '0;
        ext_term_r = '0;
        for (int i = NEXT - 1; i >= 0; i--) begin
            if (ext_en[i] && (cur_ch == EXT_SLOT[3*i +: 3])) begin
                ext_hit    = 1'b1;
                ext_term_l = WACC'($signed(ext_l[WEXT*i +: WEXT])) <<< EXT_SHL;
                ext_term_r = WACC'($signed(ext_r[WEXT*i +: WEXT])) <<< EXT_SHL;
            end
        end
        fm_term = WACC'(op_result);
        term_l  = ext_hit ? ext_term_l : fm_term;
        term_r  = ext_hit ? ext_term_r : fm_term;
        en_l    = ext_hit | (sum_en & rl[1]);
        en_r    = ext_hit | (sum_en & rl[0]);
    end

    jt10_sat_acc #(
        .WACC (WACC),
        .WOUT (WOUT)
    ) u_acc_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .zero    (zero),
        .term    (term_l),
        .term_en (en_l),
        .mute    (mute[1]),
        .dout    (left),
        .ovf     (ovf[1])
    );

    jt10_sat_acc #(
        .WACC (WACC),
        .WOUT (WOUT)
    ) u_acc_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .zero    (zero),
        .term    (term_r),
        .term_en (en_r),
        .mute    (mute[0]),
        .dout    (right),
        .ovf     (ovf[0])
    );

    // One-cycle strobe following each latched frame; drops on the next
    // edge whether or not the slot advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= 1'b0;
        end else begin
            sample <= clk_en & zero;
        end
    end

endmodule
`default_nettype wire

// File: doc/jt10_multi_acc.md
Name: jt10_multi_acc

Overview:
- Parametrised stereo frame accumulator for the YM2610-class FM/ADPCM mixer. Successor to the single-slot ADPCM-injecting accumulator.
- Sums FM operator outputs per frame, selecting which operators count by algorithm. Injects NEXT external stereo sources at programmable channel slots.
- Saturates to WOUT bits and emits a registered stereo sample with a one-cycle strobe and sticky overflow flags.
- Sits between the operator pipeline and the DAC/resampler.

Parameters:
- WIN, 14, operator result width (signed).
- WEXT, 16, external source width (signed).
- WACC, 19, internal accumulator width (signed); must be >= max(WIN,WEXT)+3.
- WOUT, 16, output sample width (signed); WOUT <= WACC.
- NEXT, 2, number of external stereo sources (1..4).
- EXT_SLOT, {3'd6,3'd2}, packed 3-bit cur_ch slot per source; source i uses bits [3i+2:3i].
- EXT_SHL, 0, left shift applied to every external term before summing (0..2).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- clk_en, in, 1, slot advance enable; all state changes only when high.
- op_result, in, WIN, signed operator output for the current slot.
- rl, in, 2, pan for the current channel: [1]=left, [0]=right.
- alg, in, 3, algorithm of the current channel.
- s1_enters, s2_enters, s3_enters, s4_enters, in, 1 each, operator-stage markers.
- cur_ch, in, 3, current channel slot.
- zero, in, 1, frame boundary marker (first slot of a frame).
- ext_l, in, NEXT*WEXT, packed signed left external samples.
- ext_r, in, NEXT*WEXT, packed signed right external samples.
- ext_en, in, NEXT, per-source enable; a disabled source's slot falls back to FM behaviour.
- mute, in, 2, [1] mutes the left output, [0] mutes the right; applied at latch time.
- left, out, WOUT, signed left sample.
- right, out, WOUT, signed right sample.
- sample, out, 1, high for exactly one clk after left/right update.
- ovf, out, 2, sticky saturation flags [1]=left, [0]=right, for the last latched frame.

Behaviour:
- Reset: acc_l, acc_r, left, right, sample and ovf all = 0. Reset is asynchronous and may assert mid-frame; the partial sum is discarded.
- FM sum enable, sum_en, by alg:
  - default: s4_enters.
  - 4: s2_enters|s4_enters.
  - 5, 6: ~s1_enters.
  - 7: 1.
- Term select per cycle:
  - If some i has ext_en[i] and cur_ch==EXT_SLOT[i], term_l = sext(ext_l[i])<<EXT_SHL and term_r likewise, both enabled unconditionally. rl and sum_en are ignored.
  - If several sources match, the lowest index wins.
  - Otherwise term = sext(op_result) to WACC; enable_l = sum_en&rl[1], enable_r = sum_en&rl[0].
  - A disabled side contributes 0.
- Accumulate (clk_en=1, zero=0): acc <= sat_WACC(acc + term). If a saturation occurs, set an internal frame-overflow bit for that side.
- Frame boundary (clk_en=1, zero=1), all on the same edge:
  - Output (left/right) <= mute side ? 0 : sat_WOUT(acc). The previous frame excludes the current term.
  - ovf side <= frame-overflow bit | (WOUT saturation occurred).
  - acc <= current term (or 0). The frame-overflow bit clears.
  - sample <= 1.
- sample returns to 0 on the next clk edge regardless of clk_en.
- Saturation: clamp to +2^(W-1)-1 / -2^(W-1). Never wrap.
- Latency: a term presented with clk_en appears in left/right on the edge of the next zero cycle. Outputs hold between frames.
- clk_en=0: all registers hold, except that sample clears.
- zero asserted on consecutive clk_en cycles: each latches a one-term frame (valid, no special case).

Decomposition:
- Package jt10_acc_pkg: saturate function (parametrised width), alg-to-sum_en decode function, ALG_* constants.
- One sub-module jt10_sat_acc: per-side WACC accumulator with saturation, frame latch, overflow bit and mute. Instantiate it twice.
- Top level: term selection, external-slot matching, and the sample strobe.

Test Plan:
- alg=7, rl=2'b11, op_result=100 over 8 slots, then zero → left=right=800, sample pulses once, ovf=0.
- alg=0, s4_enters only on the slot with op_result=-50, rl=2'b10 → left=-50, right=0.
- NEXT=2, ext_en=2'b01, cur_ch=2 with ext_l=1000, ext_r=-1000, rl=2'b00 → left=1000, right=-1000. With ext_en=2'b00, the same slot follows FM rules.
- ext_l=32767 on both slots plus FM 8191 ×6, WOUT=16 → left=32767, ovf[1]=1. The next clean frame clears ovf[1].
- mute=2'b01 during the latch → right=0, left unaffected. rst_n asserted mid-frame then released → first latched sample excludes pre-reset terms.
- clk_en held low for 5 cycles with zero high → no latch, outputs hold, sample stays 0.
